// File: rtl/rob_pkg.sv
// Shared defaults and index/count types for the re-order buffer allocation controller.
package rob_pkg;

  localparam int DEF_RENTRIES = 32;
  localparam int DEF_RSLOTS   = 3;
  localparam int DEF_CSLOTS   = 2;

  localparam int IDX_W = $clog2(DEF_RENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;

endpackage

// File: rtl/rob_commit_scan.sv
// Counts consecutive valid-and-done entries starting at the head, capped at CSLOTS.
module rob_commit_scan
  import rob_pkg::*;
#(
  parameter int RENTRIES = DEF_RENTRIES,
  parameter int CSLOTS   = DEF_CSLOTS
) (
  input  logic [$clog2(RENTRIES)-1:0] i_head,
  input  logic [RENTRIES-1:0]         i_rob_v,
  input  logic [RENTRIES-1:0]         i_rob_done,
  input  logic                        i_commit_en,
  output logic [1:0]                  o_commit_cnt
);

  localparam int IW = $clog2(RENTRIES);

  logic          w_stop;
  logic [IW-1:0] w_idx;

  // Retirement is strictly in order, so the first not-ready entry ends the scan.
  always_comb begin
    o_commit_cnt = '0;
    w_stop       = 1'b0;
    w_idx        = i_head;
    for (int k = 0; k < CSLOTS; k++) begin
      w_idx = i_head + IW'(k);
      if (!w_stop && i_commit_en && i_rob_v[w_idx] && i_rob_done[w_idx]) begin
        o_commit_cnt = o_commit_cnt + 2'd1;
      end else begin
        w_stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB tail/head pointer, entry-valid and occupancy control with in-order commit and flush recovery.
module rob_alloc_ctrl
  import rob_pkg::*;
#(
  parameter int RENTRIES = DEF_RENTRIES,
  parameter int RSLOTS   = DEF_RSLOTS,
  parameter int CSLOTS   = DEF_CSLOTS
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [2:0]                               i_alloc_cnt,
  input  logic                                     i_commit_en,
  input  logic [RENTRIES-1:0]                      i_rob_done,
  input  logic                                     i_flush,
  input  logic [$clog2(RENTRIES)-1:0]              i_flush_tail,
  output logic [RSLOTS-1:0][$clog2(RENTRIES)-1:0]  o_rob_tails,
  output logic [$clog2(RENTRIES)-1:0]              o_rob_head,
  output logic [RENTRIES-1:0]                      o_rob_v,
  output logic [1:0]                               o_commit_cnt,
  output logic [$clog2(RENTRIES):0]                o_count,
  output logic [$clog2(RENTRIES):0]                o_free_cnt,
  output logic                                     o_full,
  output logic                                     o_empty,
  output logic                                     o_alloc_err
);

  localparam int IW = $clog2(RENTRIES);
  localparam int CW = IW + 1;

  logic [IW-1:0]       r_tail;
  logic [IW-1:0]       r_head;
  logic [RENTRIES-1:0] r_rob_v;
  logic [CW-1:0]       r_count;
  logic                r_alloc_err;

  logic [IW-1:0]       w_tail_nx;
  logic [IW-1:0]       w_head_nx;
  logic [RENTRIES-1:0] w_rob_v_nx;
  logic [CW-1:0]       w_count_nx;
  logic                w_alloc_err_nx;
  logic [1:0]          w_commit_cnt;
  logic [CW-1:0]       w_free;
  logic                w_alloc_ok;
  logic [IW-1:0]       w_span;
  logic [IW-1:0]       w_idx;

  rob_commit_scan #(
    .RENTRIES (RENTRIES),
    .CSLOTS   (CSLOTS)
  ) u_scan (
    .i_head       (r_head),
    .i_rob_v      (r_rob_v),
    .i_rob_done   (i_rob_done),
    .i_commit_en  (i_commit_en & ~i_flush),
    .o_commit_cnt (w_commit_cnt)
  );

  assign w_free     = CW'(RENTRIES) - r_count;
  assign w_alloc_ok = (CW'(i_alloc_cnt) <= (w_free + CW'(w_commit_cnt)));
  assign w_span     = r_tail - i_flush_tail;

  // Commit clears run before allocation sets, so a slot freed and reused this cycle ends up valid.
  always_comb begin
    w_rob_v_nx     = r_rob_v;
    w_tail_nx      = r_tail;
    w_head_nx      = r_head + IW'(w_commit_cnt);
    w_count_nx     = r_count;
    w_alloc_err_nx = 1'b0;
    w_idx          = '0;
    if (i_flush) begin
      w_tail_nx  = i_flush_tail;
      w_count_nx = {1'b0, i_flush_tail - r_head};
      for (int i = 0; i < RENTRIES; i++) begin
        if ((IW'(i) - i_flush_tail) < w_span) begin
          w_rob_v_nx[i] = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < CSLOTS; k++) begin
        if (k < int'(w_commit_cnt)) begin
          w_idx             = r_head + IW'(k);
          w_rob_v_nx[w_idx] = 1'b0;
        end
      end
      if (w_alloc_ok) begin
        for (int k = 0; k < RSLOTS; k++) begin
          if (k < int'(i_alloc_cnt)) begin
            w_idx             = r_tail + IW'(k);
            w_rob_v_nx[w_idx] = 1'b1;
          end
        end
        w_tail_nx  = r_tail + IW'(i_alloc_cnt);
        w_count_nx = r_count + CW'(i_alloc_cnt) - CW'(w_commit_cnt);
      end else begin
        w_alloc_err_nx = 1'b1;
        w_count_nx     = r_count - CW'(w_commit_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail      <= '0;
      r_head      <= '0;
      r_rob_v     <= '0;
      r_count     <= '0;
      r_alloc_err <= 1'b0;
    end else begin
      r_tail      <= w_tail_nx;
      r_head      <= w_head_nx;
      r_rob_v     <= w_rob_v_nx;
      r_count     <= w_count_nx;
      r_alloc_err <= w_alloc_err_nx;
    end
  end

  always_comb begin
    o_rob_tails = '0;
    for (int k = 0; k < RSLOTS; k++) begin
      o_rob_tails[k] = r_tail + IW'(k);
    end
  end

  assign o_rob_head   = r_head;
  assign o_rob_v      = r_rob_v;
  assign o_commit_cnt = w_commit_cnt;
  assign o_count      = r_count;
  assign o_free_cnt   = w_free;
  assign o_full       = (r_count == CW'(RENTRIES));
  assign o_empty      = (r_count == '0);
  assign o_alloc_err  = r_alloc_err;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Vector-table and scoreboard bench for rob_alloc_ctrl with a 16-entry ROB.
module tb_rob_alloc_ctrl;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int CW = 5;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [2:0]              allocCnt = '0;
  logic                    commitEn = 1'b0;
  logic [N-1:0]            robDone = '0;
  logic                    flush = 1'b0;
  logic [IW-1:0]           flushTail = '0;
  logic [2:0][IW-1:0]      robTails;
  logic [IW-1:0]           robHead;
  logic [N-1:0]            robV;
  logic [1:0]              commitCnt;
  logic [CW-1:0]           count;
  logic [CW-1:0]           freeCnt;
  logic                    full;
  logic                    empty;
  logic                    allocErr;

  typedef struct {
    logic [2:0]    alloc;
    logic          cen;
    logic [N-1:0]  done;
    logic          fl;
    logic [IW-1:0] ftail;
    logic [1:0]    expCommit;
    logic [N-1:0]  expV;
    logic [IW-1:0] expHead;
    logic [IW-1:0] expTail;
    logic [CW-1:0] expCount;
    logic          expErr;
  } vec_t;

  vec_t expQ[$];
  vec_t vecs[12];
  int   nVectors = 0;
  int   nCompares = 0;
  int   nMiscompares = 0;

  rob_alloc_ctrl #(.RENTRIES(N), .RSLOTS(3), .CSLOTS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_alloc_cnt  (allocCnt),
    .i_commit_en  (commitEn),
    .i_rob_done   (robDone),
    .i_flush      (flush),
    .i_flush_tail (flushTail),
    .o_rob_tails  (robTails),
    .o_rob_head   (robHead),
    .o_rob_v      (robV),
    .o_commit_cnt (commitCnt),
    .o_count      (count),
    .o_free_cnt   (freeCnt),
    .o_full       (full),
    .o_empty      (empty),
    .o_alloc_err  (allocErr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] a, input logic c, input logic [N-1:0] d,
                              input logic f, input logic [IW-1:0] ft, input logic [1:0] ec,
                              input logic [N-1:0] ev, input logic [IW-1:0] eh,
                              input logic [IW-1:0] et, input logic [CW-1:0] ecnt, input logic ee);
    vec_t v;
    v.alloc = a; v.cen = c; v.done = d; v.fl = f; v.ftail = ft;
    v.expCommit = ec; v.expV = ev; v.expHead = eh; v.expTail = et;
    v.expCount = ecnt; v.expErr = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompares++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    allocCnt = '0; commitEn = 1'b0; robDone = '0; flush = 1'b0; flushTail = '0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".rob_v"}, 32'(robV), 32'h0);
    check({tag, ".head"}, 32'(robHead), 32'd0);
    check({tag, ".tail0"}, 32'(robTails[0]), 32'd0);
    check({tag, ".tail1"}, 32'(robTails[1]), 32'd1);
    check({tag, ".tail2"}, 32'(robTails[2]), 32'd2);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".free"}, 32'(freeCnt), 32'd16);
    check({tag, ".empty"}, 32'(empty), 32'd1);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".alloc_err"}, 32'(allocErr), 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (expQ.size() == 0) begin
      nMiscompares++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, want one entry", tag);
      return;
    end
    e = expQ.pop_front();
    check({tag, ".rob_v"}, 32'(robV), 32'(e.expV));
    check({tag, ".head"}, 32'(robHead), 32'(e.expHead));
    check({tag, ".tail0"}, 32'(robTails[0]), 32'(e.expTail));
    check({tag, ".tail1"}, 32'(robTails[1]), 32'(IW'(e.expTail + 4'd1)));
    check({tag, ".tail2"}, 32'(robTails[2]), 32'(IW'(e.expTail + 4'd2)));
    check({tag, ".count"}, 32'(count), 32'(e.expCount));
    check({tag, ".free"}, 32'(freeCnt), 32'(5'd16 - e.expCount));
    check({tag, ".full"}, 32'(full), 32'(e.expCount == 5'd16));
    check({tag, ".empty"}, 32'(empty), 32'(e.expCount == 5'd0));
    check({tag, ".alloc_err"}, 32'(allocErr), 32'(e.expErr));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    allocCnt = v.alloc; commitEn = v.cen; robDone = v.done; flush = v.fl; flushTail = v.ftail;
    nVectors++;
    expQ.push_back(v);
    #1;
    check({tag, ".commit_cnt"}, 32'(commitCnt), 32'(v.expCommit));
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // alloc, cen, done, flush, ftail | commit, rob_v, head, tail, count, err
    vecs[0]  = mk(3, 0, 16'h0000, 0, 0, 0, 16'h0007, 0, 3, 3, 0);
    vecs[1]  = mk(0, 1, 16'h0005, 0, 0, 1, 16'h0006, 1, 3, 2, 0);
    vecs[2]  = mk(2, 1, 16'h0006, 0, 0, 2, 16'h0018, 3, 5, 2, 0);
    vecs[3]  = mk(3, 0, 16'h0000, 0, 0, 0, 16'h00F8, 3, 8, 5, 0);
    vecs[4]  = mk(3, 0, 16'h0000, 0, 0, 0, 16'h07F8, 3, 11, 8, 0);
    vecs[5]  = mk(3, 0, 16'h0000, 0, 0, 0, 16'h3FF8, 3, 14, 11, 0);
    vecs[6]  = mk(3, 0, 16'h0000, 0, 0, 0, 16'hFFF9, 3, 1, 14, 0);
    vecs[7]  = mk(2, 0, 16'h0000, 0, 0, 0, 16'hFFFF, 3, 3, 16, 0);
    vecs[8]  = mk(1, 1, 16'h0000, 0, 0, 0, 16'hFFFF, 3, 3, 16, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'hFFFF, 3, 3, 16, 0);
    vecs[10] = mk(2, 1, 16'h0018, 0, 0, 2, 16'hFFFF, 5, 5, 16, 0);
    vecs[11] = mk(3, 1, 16'h0020, 0, 0, 1, 16'hFFDF, 6, 5, 15, 1);

    driveIdle();
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Walk head round to 14 with steady 2-in/2-out traffic, then flush across the wrap.
    @(negedge clk);
    driveIdle();
    rst_n = 1'b0;
    #1;
    checkResetState("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(2, 0, 16'h0000, 0, 0, 0, 16'h0003, 0, 2, 2, 0), "prime");
    for (int i = 1; i <= 7; i++) begin
      logic [N-1:0] ev;
      ev = '0;
      ev[(2 * i) % 16] = 1'b1;
      ev[(2 * i + 1) % 16] = 1'b1;
      applyStimulus(mk(2, 1, 16'hFFFF, 0, 0, 2, ev, IW'((2 * i) % 16), IW'((2 * i + 2) % 16), 2, 0),
                    $sformatf("stream%0d", i));
    end
    applyStimulus(mk(3, 0, 16'h0000, 0, 0, 0, 16'hC007, 14, 3, 5, 0), "pre_flush_a");
    applyStimulus(mk(1, 0, 16'h0000, 0, 0, 0, 16'hC00F, 14, 4, 6, 0), "pre_flush_b");
    applyStimulus(mk(3, 1, 16'hFFFF, 1, 1, 0, 16'hC001, 14, 1, 3, 0), "flush");
    applyStimulus(mk(1, 0, 16'h0000, 0, 0, 0, 16'hC003, 14, 2, 4, 0), "post_flush");
    applyStimulus(mk(0, 1, 16'hFFFF, 0, 0, 2, 16'h0003, 0, 2, 2, 0), "head_wrap");

    // Build a burst to nine entries, then drop reset between clock edges.
    applyStimulus(mk(3, 0, 16'h0000, 0, 0, 0, 16'h001F, 0, 5, 5, 0), "burst_a");
    applyStimulus(mk(3, 0, 16'h0000, 0, 0, 0, 16'h00FF, 0, 8, 8, 0), "burst_b");
    applyStimulus(mk(1, 0, 16'h0000, 0, 0, 0, 16'h01FF, 0, 9, 9, 0), "burst_c");
    driveIdle();
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(3, 0, 16'h0000, 0, 0, 0, 16'h0007, 0, 3, 3, 0), "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
